dma_channel: RTL and testbench

//  Single-channel DMA engine between a disk controller (RK/IDE) and the bus arbiter's dma_* port.

---
 rtl/dma_channel.sv | 152 +++++++++++++++
 tb/tb_dma_channel.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel.sv
// rtl/dma_channel.sv - single-channel DMA engine moving words between a device FIFO and the bus arbiter port
module dma_channel #(
  parameter int DEPTH = 4,
  parameter int AW    = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [15:0]   word_count,
  input  logic          to_mem,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [AW-1:0] cur_addr,
  output logic [15:0]   words_left,
  input  logic [15:0]   dev_wdata,
  input  logic          dev_wvalid,
  output logic          dev_wready,
  output logic [15:0]   dev_rdata,
  output logic          dev_rvalid,
  input  logic          dev_rready,
  output logic          dma_req,
  input  logic          dma_ack,
  output logic [AW-1:0] dma_addr,
  input  logic [15:0]   dma_data_in,
  output logic [15:0]   dma_data_out,
  output logic          dma_rd,
  output logic          dma_wr
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_FIN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_words_left;
  logic [15:0]   r_push_left;
  logic          r_to_mem;
  logic          r_aborted;
  logic [15:0]   r_fifo [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_active;
  logic          w_abort;
  logic          w_req;
  logic          w_rd;
  logic          w_wr;
  logic          w_push;
  logic          w_pop;
  logic [15:0]   w_push_data;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == (PW+1)'(DEPTH));
  assign w_active = (r_state == S_XFER) || (r_state == S_DRAIN);
  assign w_abort  = w_active && abort;

  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (word_count == '0) ? S_FIN : S_XFER;
      end
      S_XFER: begin
        if (r_to_mem) begin
          w_req = !w_empty;
          w_wr  = dma_ack && !w_empty && !abort;
        end else begin
          w_req = !w_full && (r_words_left != '0);
          w_rd  = dma_ack && w_req && !abort;
        end
        if (abort) w_next = S_FIN;
        else if ((w_rd || w_wr) && (r_words_left == 16'd1)) w_next = r_to_mem ? S_FIN : S_DRAIN;
      end
      S_DRAIN: begin
        if (abort || w_empty) w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Device pushes are limited to the latched word count so the FIFO never holds surplus words.
  assign dev_wready  = (r_state == S_XFER) && r_to_mem && !w_full && (r_push_left != '0);
  assign dev_rvalid  = w_active && !r_to_mem && !w_empty;
  assign w_push      = r_to_mem ? (dev_wvalid && dev_wready) : w_rd;
  assign w_pop       = r_to_mem ? w_wr : (dev_rvalid && dev_rready);
  assign w_push_data = r_to_mem ? dev_wdata : dma_data_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_words_left <= '0;
      r_push_left  <= '0;
      r_to_mem     <= 1'b0;
      r_aborted    <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_addr       <= start_addr & ~AW'(1);
        r_words_left <= word_count;
        r_push_left  <= word_count;
        r_to_mem     <= to_mem;
        r_aborted    <= 1'b0;
      end else if (w_rd || w_wr) begin
        r_addr       <= r_addr + AW'(2);
        r_words_left <= r_words_left - 16'd1;
      end
      if (w_abort) r_aborted <= 1'b1;
      if (dev_wvalid && dev_wready && !abort) r_push_left <= r_push_left - 16'd1;
      if (w_abort) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PW'(1);
        if (w_pop)  r_rptr <= r_rptr + PW'(1);
        if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
        else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_abort) r_fifo[r_wptr] <= w_push_data;
  end

  assign busy         = w_active;
  assign done         = (r_state == S_FIN);
  assign aborted      = (r_state == S_FIN) && r_aborted;
  assign cur_addr     = r_addr;
  assign words_left   = r_words_left;
  assign dma_addr     = r_addr;
  assign dma_req      = w_req;
  assign dma_rd       = w_rd;
  assign dma_wr       = w_wr;
  assign dev_rdata    = r_fifo[r_rptr];
  assign dma_data_out = r_fifo[r_rptr];
endmodule

// File: tb/tb_dma_channel.sv
// tb/tb_dma_channel.sv - randomized self-checking bench for dma_channel against a queue-based transfer model
module tb_dma_channel;
  localparam int AW    = 18;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [15:0]   word_count = '0;
  logic          to_mem = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, aborted;
  logic [AW-1:0] cur_addr;
  logic [15:0]   words_left;
  logic [15:0]   dev_wdata = '0;
  logic          dev_wvalid = 1'b0;
  logic          dev_wready;
  logic [15:0]   dev_rdata;
  logic          dev_rvalid;
  logic          dev_rready = 1'b0;
  logic          dma_req;
  logic          dma_ack = 1'b0;
  logic [AW-1:0] dma_addr;
  logic [15:0]   dma_data_in;
  logic [15:0]   dma_data_out;
  logic          dma_rd, dma_wr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dma_channel #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .word_count(word_count),
    .to_mem(to_mem), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .cur_addr(cur_addr), .words_left(words_left), .dev_wdata(dev_wdata), .dev_wvalid(dev_wvalid),
    .dev_wready(dev_wready), .dev_rdata(dev_rdata), .dev_rvalid(dev_rvalid), .dev_rready(dev_rready),
    .dma_req(dma_req), .dma_ack(dma_ack), .dma_addr(dma_addr), .dma_data_in(dma_data_in),
    .dma_data_out(dma_data_out), .dma_rd(dma_rd), .dma_wr(dma_wr)
  );

  // Memory image seen by the engine: a fixed scramble of the byte address.
  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    logic [15:0] t;
    t = a[15:0] * 16'd40503;
    return t ^ {14'h0, a[17:16]} ^ 16'h5A3C;
  endfunction

  always_comb dma_data_in = mem_word(dma_addr);

  int            cyc = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [15:0]   wr_data_q[$];
  logic [AW-1:0] rd_addr_q[$];
  logic [15:0]   pop_q[$];
  logic [15:0]   src_q[$];
  int            src_idx = 0;
  int            done_cnt = 0, done_cyc = 0, last_pop_cyc = 0, viol = 0;
  bit            done_ab = 0, req_seen = 0, last_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (dma_wr) begin
        wr_addr_q.push_back(dma_addr);
        wr_data_q.push_back(dma_data_out);
      end
      if (dma_rd) rd_addr_q.push_back(dma_addr);
      if (dev_rvalid && dev_rready) begin
        pop_q.push_back(dev_rdata);
        last_pop_cyc = cyc;
      end
      if ((dma_rd && dma_wr) || ((dma_rd || dma_wr) && !dma_ack)) viol++;
      if (dma_req) req_seen = 1;
      last_req = dma_req;
      if (done) begin
        done_cnt++;
        done_ab  = aborted;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); pop_q.delete();
    done_cnt = 0; req_seen = 0; src_idx = 0;
  endtask

  task automatic start_xfer(input bit tm, input logic [AW-1:0] a, input logic [15:0] wc);
    @(posedge clk); #1;
    clear_log();
    start = 1; to_mem = tm; start_addr = a; word_count = wc;
    dma_ack = 0; dev_wvalid = 0; dev_rready = 0; abort = 0;
    @(posedge clk); #1;
    start = 0; start_addr = AW'($urandom); word_count = 16'($urandom); to_mem = 1'($urandom);
  endtask

  // ack_mode: 0 held high, 1 four-cycle grant bursts, 2 random. dev_mode: 0 idle, 1 always, 2 random.
  task automatic drive_cycles(input int n, input int ack_mode, input int dev_mode);
    for (int c = 0; c < n && done_cnt == 0; c++) begin
      case (ack_mode)
        0:       dma_ack = 1'b1;
        1:       dma_ack = (cyc % 7) < 4;
        default: dma_ack = 1'($urandom_range(0, 1));
      endcase
      dev_wvalid = (src_idx < src_q.size()) && (dev_mode == 1 || (dev_mode == 2 && $urandom_range(0, 2) != 0));
      dev_wdata  = (src_idx < src_q.size()) ? src_q[src_idx] : 16'($urandom);
      dev_rready = (dev_mode == 1) || (dev_mode == 2 && $urandom_range(0, 1) == 1);
      @(negedge clk);
      if (dev_wvalid && dev_wready) src_idx++;
      @(posedge clk); #1;
    end
    dma_ack = 0; dev_wvalid = 0; dev_rready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, aborted, dma_req, dma_rd, dma_wr, dev_wready, dev_rvalid} !== 8'b0)
      $display("FAIL reset_flags: got %b expected 00000000", {busy, done, aborted, dma_req, dma_rd, dma_wr, dev_wready, dev_rvalid});
    else n_pass++;
    n_checks++;
    if (cur_addr !== '0) $display("FAIL reset_cur_addr: got %o expected 0", cur_addr); else n_pass++;
    n_checks++;
    if (words_left !== '0) $display("FAIL reset_words_left: got %0d expected 0", words_left); else n_pass++;
  endtask

  task automatic test_reset_mid_xfer();
    src_q.delete();
    for (int i = 0; i < 8; i++) src_q.push_back(16'($urandom));
    start_xfer(1, 18'o2000, 8);
    drive_cycles(3, 0, 1);
    dma_ack = 1; dev_wvalid = 1;
    @(negedge clk);
    n_checks++;
    if (dma_wr !== 1'b1) $display("FAIL rst_pre_wr: got %b expected 1", dma_wr); else n_pass++;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    n_checks++;
    if ({dma_req, dma_wr, busy} !== 3'b000 || words_left !== 16'd0 || cur_addr !== '0)
      $display("FAIL rst_mid_xfer: got req/wr/busy=%b words_left=%0d cur_addr=%o expected 000/0/0", {dma_req, dma_wr, busy}, words_left, cur_addr);
    else n_pass++;
    dma_ack = 0; dev_wvalid = 0;
  endtask

  task automatic test_to_mem_basic();
    int bad;
    src_q = '{16'o11, 16'o22, 16'o33};
    start_xfer(1, 18'o1000, 3);
    drive_cycles(100, 0, 1);
    n_checks++;
    if (done_cnt !== 1 || done_ab !== 0) $display("FAIL wr3_done: got count=%0d aborted=%b expected 1/0", done_cnt, done_ab); else n_pass++;
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (i >= 3 || wr_addr_q[i] !== 18'o1000 + AW'(2 * i) || wr_data_q[i] !== src_q[i]) bad++;
    n_checks++;
    if (bad !== 0 || wr_addr_q.size() !== 3) $display("FAIL wr3_writes: got %0d writes, %0d wrong, expected 3 writes 0 wrong", wr_addr_q.size(), bad); else n_pass++;
    n_checks++;
    if (cur_addr !== 18'o1006) $display("FAIL wr3_cur_addr: got %o expected 1006", cur_addr); else n_pass++;
  endtask

  task automatic test_read_bursts();
    int bad;
    logic [AW-1:0] a;
    a = AW'($urandom) & ~AW'(1);
    src_q.delete();
    start_xfer(0, a, 6);
    drive_cycles(400, 1, 2);
    bad = 0;
    for (int i = 0; i < rd_addr_q.size(); i++) if (rd_addr_q[i] !== a + AW'(2 * i)) bad++;
    n_checks++;
    if (bad !== 0 || rd_addr_q.size() !== 6) $display("FAIL rd6_reads: got %0d reads, %0d wrong, expected 6 reads 0 wrong", rd_addr_q.size(), bad); else n_pass++;
    bad = 0;
    for (int i = 0; i < pop_q.size(); i++) if (pop_q[i] !== mem_word(a + AW'(2 * i))) bad++;
    n_checks++;
    if (bad !== 0 || pop_q.size() !== 6) $display("FAIL rd6_pops: got %0d pops, %0d wrong, expected 6 pops 0 wrong", pop_q.size(), bad); else n_pass++;
    n_checks++;
    if (done_cnt !== 1 || done_cyc <= last_pop_cyc) $display("FAIL rd6_done_after_pop: got done_count=%0d done_cyc=%0d last_pop=%0d expected 1 and later", done_cnt, done_cyc, last_pop_cyc); else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad;
    logic [AW-1:0] a;
    a = 18'o40000;
    src_q.delete();
    start_xfer(0, a, 8);
    drive_cycles(12, 0, 0);
    n_checks++;
    if (rd_addr_q.size() !== DEPTH || last_req !== 1'b0 || busy !== 1'b1)
      $display("FAIL bp_stall: got reads=%0d req=%b busy=%b expected %0d/0/1", rd_addr_q.size(), last_req, busy, DEPTH);
    else n_pass++;
    drive_cycles(200, 0, 1);
    bad = 0;
    for (int i = 0; i < pop_q.size(); i++) if (pop_q[i] !== mem_word(a + AW'(2 * i))) bad++;
    n_checks++;
    if (done_cnt !== 1 || rd_addr_q.size() !== 8 || pop_q.size() !== 8 || bad !== 0)
      $display("FAIL bp_resume: got done=%0d reads=%0d pops=%0d wrong=%0d expected 1/8/8/0", done_cnt, rd_addr_q.size(), pop_q.size(), bad);
    else n_pass++;
  endtask

  task automatic test_zero_count();
    start_xfer(1, 18'o1234, 0);
    dma_ack = 1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL wc0_done: got done=%b busy=%b expected 1/0", done, busy); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || req_seen !== 1'b0 || wr_addr_q.size() !== 0 || rd_addr_q.size() !== 0)
      $display("FAIL wc0_quiet: got done=%b req_seen=%b wr=%0d rd=%0d expected 0/0/0/0", done, req_seen, wr_addr_q.size(), rd_addr_q.size());
    else n_pass++;
    dma_ack = 0;
  endtask

  task automatic test_wrap();
    src_q = '{16'($urandom), 16'($urandom)};
    start_xfer(1, 18'o777776, 2);
    drive_cycles(100, 0, 1);
    n_checks++;
    if (wr_addr_q.size() !== 2) $display("FAIL wrap_count: got %0d writes expected 2", wr_addr_q.size());
    else if (wr_addr_q[0] !== 18'o777776 || wr_addr_q[1] !== 18'o0 || wr_data_q[0] !== src_q[0] || wr_data_q[1] !== src_q[1])
      $display("FAIL wrap_addr: got %o,%o expected 777776,000000", wr_addr_q[0], wr_addr_q[1]);
    else n_pass++;
    n_checks++;
    if (cur_addr !== 18'o2) $display("FAIL wrap_cur_addr: got %o expected 2", cur_addr); else n_pass++;
  endtask

  task automatic test_abort();
    logic [AW-1:0] b;
    src_q.delete();
    start_xfer(0, 18'o3000, 8);
    drive_cycles(2, 0, 0);
    dma_ack = 1; abort = 1;
    @(negedge clk);
    n_checks++;
    if (dma_rd !== 1'b0 || dma_wr !== 1'b0) $display("FAIL abort_strobe: got rd=%b wr=%b expected 0/0", dma_rd, dma_wr); else n_pass++;
    @(posedge clk); #1;
    abort = 0; dma_ack = 0;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || rd_addr_q.size() !== 2)
      $display("FAIL abort_done: got done=%b aborted=%b reads=%0d expected 1/1/2", done, aborted, rd_addr_q.size());
    else n_pass++;
    b = 18'o7000;
    start_xfer(0, b, 2);
    drive_cycles(100, 0, 1);
    n_checks++;
    if (pop_q.size() !== 2 || done_ab !== 1'b0) $display("FAIL abort_flush: got pops=%0d aborted=%b expected 2/0", pop_q.size(), done_ab);
    else if (pop_q[0] !== mem_word(b) || pop_q[1] !== mem_word(b + AW'(2)))
      $display("FAIL abort_flush_data: got %h,%h expected %h,%h", pop_q[0], pop_q[1], mem_word(b), mem_word(b + AW'(2)));
    else n_pass++;
  endtask

  task automatic test_start_busy();
    int bad;
    logic [AW-1:0] a;
    a = 18'o5000;
    src_q.delete();
    start_xfer(0, a, 4);
    drive_cycles(2, 0, 0);
    start = 1; start_addr = 18'o6000; word_count = 10; to_mem = 1;
    drive_cycles(1, 0, 0);
    start = 0;
    drive_cycles(200, 0, 1);
    bad = 0;
    for (int i = 0; i < pop_q.size(); i++) if (pop_q[i] !== mem_word(a + AW'(2 * i)) || rd_addr_q[i] !== a + AW'(2 * i)) bad++;
    n_checks++;
    if (done_cnt !== 1 || rd_addr_q.size() !== 4 || pop_q.size() !== 4 || wr_addr_q.size() !== 0 || bad !== 0)
      $display("FAIL start_busy: got done=%0d reads=%0d pops=%0d writes=%0d wrong=%0d expected 1/4/4/0/0", done_cnt, rd_addr_q.size(), pop_q.size(), wr_addr_q.size(), bad);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      bit            tm;
      int            wc, bad;
      logic [AW-1:0] a, a0;
      tm = 1'($urandom_range(0, 1));
      wc = $urandom_range(1, 12);
      a  = AW'($urandom);
      a0 = a & ~AW'(1);
      src_q.delete();
      if (tm) for (int i = 0; i < wc; i++) src_q.push_back(16'($urandom));
      start_xfer(tm, a, 16'(wc));
      drive_cycles(800, 2, 2);
      bad = 0;
      if (tm) begin
        for (int i = 0; i < wr_addr_q.size(); i++)
          if (i >= wc || wr_addr_q[i] !== a0 + AW'(2 * i) || wr_data_q[i] !== src_q[i]) bad++;
        if (wr_addr_q.size() != wc || rd_addr_q.size() != 0) bad++;
      end else begin
        for (int i = 0; i < pop_q.size(); i++)
          if (i >= wc || pop_q[i] !== mem_word(a0 + AW'(2 * i))) bad++;
        for (int i = 0; i < rd_addr_q.size(); i++)
          if (rd_addr_q[i] !== a0 + AW'(2 * i)) bad++;
        if (pop_q.size() != wc || rd_addr_q.size() != wc || wr_addr_q.size() != 0) bad++;
      end
      n_checks++;
      if (done_cnt !== 1 || bad !== 0)
        $display("FAIL random_%0d: to_mem=%b wc=%0d got done=%0d errors=%0d expected 1/0", t, tm, wc, done_cnt, bad);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_xfer();
    test_to_mem_basic();
    test_read_bursts();
    test_backpressure();
    test_zero_count();
    test_wrap();
    test_abort();
    test_start_busy();
    test_random();
    n_checks++;
    if (viol !== 0) $display("FAIL strobe_rules: got %0d violating cycles expected 0", viol); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
